// File: rtl/axi_aw_w_arbiter.sv
// Round-robin arbiter sharing one AXI4 write path (AW/W/B) among requesters; index prepended to AWID.
// Latency: 1 cycle request->m_axi_awvalid; W and B paths combinational; one IDLE cycle between bursts.
// Backpressure: AW stalls while out_cnt is at C_MAX_OUTSTANDING; W/B readies pass straight through.
module axi_aw_w_arbiter #(
    parameter int C_NUM_MASTERS     = 4,
    parameter int C_ADDR_WIDTH      = 32,
    parameter int C_DATA_WIDTH      = 32,
    parameter int C_STRB_WIDTH      = C_DATA_WIDTH / 8,
    parameter int C_ID_WIDTH        = 4,
    parameter int C_IDX_WIDTH       = $clog2(C_NUM_MASTERS),
    parameter int C_MAX_OUTSTANDING = 8
) (
    input  logic                                    clk,
    input  logic                                    reset,
    input  logic [C_NUM_MASTERS*C_ID_WIDTH-1:0]     s_axi_awid,
    input  logic [C_NUM_MASTERS*C_ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic [C_NUM_MASTERS*8-1:0]              s_axi_awlen,
    input  logic [C_NUM_MASTERS-1:0]                s_axi_awvalid,
    output logic [C_NUM_MASTERS-1:0]                s_axi_awready,
    input  logic [C_NUM_MASTERS*C_DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [C_NUM_MASTERS*C_STRB_WIDTH-1:0]   s_axi_wstrb,
    input  logic [C_NUM_MASTERS-1:0]                s_axi_wlast,
    input  logic [C_NUM_MASTERS-1:0]                s_axi_wvalid,
    output logic [C_NUM_MASTERS-1:0]                s_axi_wready,
    output logic [C_NUM_MASTERS*C_ID_WIDTH-1:0]     s_axi_bid,
    output logic [C_NUM_MASTERS*2-1:0]              s_axi_bresp,
    output logic [C_NUM_MASTERS-1:0]                s_axi_bvalid,
    input  logic [C_NUM_MASTERS-1:0]                s_axi_bready,
    output logic [C_IDX_WIDTH+C_ID_WIDTH-1:0]       m_axi_awid,
    output logic [C_ADDR_WIDTH-1:0]                 m_axi_awaddr,
    output logic [7:0]                              m_axi_awlen,
    output logic                                    m_axi_awvalid,
    input  logic                                    m_axi_awready,
    output logic [C_DATA_WIDTH-1:0]                 m_axi_wdata,
    output logic [C_STRB_WIDTH-1:0]                 m_axi_wstrb,
    output logic                                    m_axi_wlast,
    output logic                                    m_axi_wvalid,
    input  logic                                    m_axi_wready,
    input  logic [C_IDX_WIDTH+C_ID_WIDTH-1:0]       m_axi_bid,
    input  logic [1:0]                              m_axi_bresp,
    input  logic                                    m_axi_bvalid,
    output logic                                    m_axi_bready,
    output logic [C_IDX_WIDTH-1:0]                  grant_idx,
    output logic                                    busy,
    output logic                                    bid_err
);
    localparam int         MID_W   = C_IDX_WIDTH + C_ID_WIDTH;
    localparam logic [7:0] MAX_OUT = 8'(C_MAX_OUTSTANDING);
    localparam logic [C_IDX_WIDTH-1:0] LAST_IDX = C_IDX_WIDTH'(C_NUM_MASTERS - 1);

    typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

    typedef struct packed {
        logic [MID_W-1:0]        id;
        logic [C_ADDR_WIDTH-1:0] addr;
        logic [7:0]              len;
    } aw_t;

    state_t                 state, state_nxt;
    aw_t                    aw_q;
    logic [C_IDX_WIDTH-1:0] rr_ptr, grant_q, pick, b_idx;
    logic                   pick_vld, arb_ok, aw_hs, b_hs, b_idx_ok, w_hs_last;
    logic [7:0]             out_cnt;

    // First requester with awvalid at or above rr_ptr, wrapping; descending loop so the nearest wins.
    always_comb begin : rr_search
        int j;
        j        = 0;
        pick     = '0;
        pick_vld = 1'b0;
        for (int k = C_NUM_MASTERS - 1; k >= 0; k--) begin
            j = int'(rr_ptr) + k;
            if (j >= C_NUM_MASTERS) j = j - C_NUM_MASTERS;
            if (s_axi_awvalid[C_IDX_WIDTH'(j)]) begin
                pick     = C_IDX_WIDTH'(j);
                pick_vld = 1'b1;
            end
        end
    end

    assign arb_ok    = pick_vld && (out_cnt < MAX_OUT);
    assign aw_hs     = (state == ADDR) && m_axi_awready;
    assign w_hs_last = s_axi_wvalid[grant_q] && m_axi_wready && s_axi_wlast[grant_q];

    always_comb begin
        state_nxt     = state;
        s_axi_awready = '0;
        s_axi_wready  = '0;
        m_axi_awvalid = 1'b0;
        m_axi_wvalid  = 1'b0;
        case (state)
            IDLE: begin
                if (arb_ok) begin
                    s_axi_awready[pick] = 1'b1;
                    state_nxt           = ADDR;
                end
            end
            ADDR: begin
                m_axi_awvalid = 1'b1;
                if (m_axi_awready) state_nxt = DATA;
            end
            DATA: begin
                m_axi_wvalid           = s_axi_wvalid[grant_q];
                s_axi_wready[grant_q]  = m_axi_wready;
                if (w_hs_last) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        // Handshake outputs stay quiet for the whole reset cycle, not just after it.
        if (reset) begin
            s_axi_awready = '0;
            s_axi_wready  = '0;
            m_axi_awvalid = 1'b0;
            m_axi_wvalid  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            rr_ptr  <= '0;
            grant_q <= '0;
            aw_q    <= '0;
            out_cnt <= '0;
            bid_err <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && arb_ok) begin
                grant_q   <= pick;
                rr_ptr    <= (pick == LAST_IDX) ? '0 : pick + 1'b1;
                aw_q.id   <= {pick, s_axi_awid[pick*C_ID_WIDTH +: C_ID_WIDTH]};
                aw_q.addr <= s_axi_awaddr[pick*C_ADDR_WIDTH +: C_ADDR_WIDTH];
                aw_q.len  <= s_axi_awlen[pick*8 +: 8];
            end
            if (aw_hs && !b_hs)
                out_cnt <= out_cnt + 8'd1;
            else if (!aw_hs && b_hs && out_cnt != 8'd0)
                out_cnt <= out_cnt - 8'd1;
            bid_err <= b_hs && !b_idx_ok;
        end
    end

    assign m_axi_awid   = aw_q.id;
    assign m_axi_awaddr = aw_q.addr;
    assign m_axi_awlen  = aw_q.len;
    assign m_axi_wdata  = s_axi_wdata[grant_q*C_DATA_WIDTH +: C_DATA_WIDTH];
    assign m_axi_wstrb  = s_axi_wstrb[grant_q*C_STRB_WIDTH +: C_STRB_WIDTH];
    assign m_axi_wlast  = s_axi_wlast[grant_q];
    assign grant_idx    = grant_q;
    assign busy         = (state != IDLE);

    // B path: index bits pick the requester; out-of-range indices are sunk so the slave never stalls.
    assign b_idx    = m_axi_bid[MID_W-1 -: C_IDX_WIDTH];
    assign b_idx_ok = 32'(b_idx) < 32'(C_NUM_MASTERS);
    assign b_hs     = m_axi_bvalid && m_axi_bready;

    assign s_axi_bid   = {C_NUM_MASTERS{m_axi_bid[C_ID_WIDTH-1:0]}};
    assign s_axi_bresp = {C_NUM_MASTERS{m_axi_bresp}};

    always_comb begin
        s_axi_bvalid = '0;
        m_axi_bready = 1'b1;
        if (b_idx_ok) begin
            s_axi_bvalid[b_idx] = m_axi_bvalid;
            m_axi_bready        = s_axi_bready[b_idx];
        end
    end
endmodule

// File: doc/axi_aw_w_arbiter.md
Name: axi_aw_w_arbiter

Overview:
- Shares one AXI4 write path (AW, W, B) between C_NUM_MASTERS upstream requesters, using round-robin arbitration on AW.
- Each grant is held until the whole W burst of the granted transaction completes (wlast handshake).
- Requester index is prepended to AWID so B responses route back to the right requester.
- Sits in the interconnect between the requester ports and a downstream axi_fifo slave port. Outstanding writes are capped by a counter.

Parameters:
- C_NUM_MASTERS, 4, number of requesters, 2..8.
- C_ADDR_WIDTH, 32, address width.
- C_DATA_WIDTH, 32, data width.
- C_STRB_WIDTH, C_DATA_WIDTH/8, strobe width.
- C_ID_WIDTH, 4, requester-side ID width.
- C_IDX_WIDTH, $clog2(C_NUM_MASTERS), requester index width.
- C_MAX_OUTSTANDING, 8, max writes accepted downstream without a B response, 1..255.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- s_axi_awid  in  N*C_ID_WIDTH  per-requester AWID; requester i occupies slice i.
- s_axi_awaddr  in  N*C_ADDR_WIDTH  per-requester address.
- s_axi_awlen  in  N*8  per-requester burst length.
- s_axi_awvalid  in  N  AW valid.
- s_axi_awready  out  N  AW ready.
- s_axi_wdata  in  N*C_DATA_WIDTH  write data.
- s_axi_wstrb  in  N*C_STRB_WIDTH  write strobes.
- s_axi_wlast  in  N  last beat.
- s_axi_wvalid  in  N  W valid.
- s_axi_wready  out  N  W ready.
- s_axi_bid  out  N*C_ID_WIDTH  returned ID (index bits stripped).
- s_axi_bresp  out  N*2  response.
- s_axi_bvalid  out  N  B valid.
- s_axi_bready  in  N  B ready.
- m_axi_awid  out  C_IDX_WIDTH+C_ID_WIDTH  {index, awid}.
- m_axi_awaddr  out  C_ADDR_WIDTH  address.
- m_axi_awlen  out  8  burst length.
- m_axi_awvalid  out  1  AW valid.
- m_axi_awready  in  1  AW ready.
- m_axi_wdata  out  C_DATA_WIDTH  write data.
- m_axi_wstrb  out  C_STRB_WIDTH  write strobes.
- m_axi_wlast  out  1  last beat.
- m_axi_wvalid  out  1  W valid.
- m_axi_wready  in  1  W ready.
- m_axi_bid  in  C_IDX_WIDTH+C_ID_WIDTH  response ID.
- m_axi_bresp  in  2  response.
- m_axi_bvalid  in  1  B valid.
- m_axi_bready  out  1  B ready.
- grant_idx  out  C_IDX_WIDTH  current or last grant.
- busy  out  1  state != IDLE.
- bid_err  out  1  one-cycle pulse: B dropped because its index >= N.

Behaviour:
- Reset (synchronous, active-high, any state, including mid-burst):
  - State returns to IDLE; rr_ptr, grant_idx and out_cnt return to 0.
  - m_axi_awvalid=0; all s_axi_awready and s_axi_wready = 0; bid_err=0.
  - In-flight beats are abandoned; no partial-burst recovery.
- FSM IDLE:
  - Arbitration is eligible when any s_axi_awvalid is high and out_cnt < C_MAX_OUTSTANDING.
  - Grant g = first requester with awvalid set, searching from rr_ptr upward and wrapping at N.
  - In the same cycle: s_axi_awready[g]=1; AW fields of g plus g are registered into m_axi_aw*; grant_idx<=g; rr_ptr<=(g+1) mod N; next state ADDR.
  - s_axi_awready stays 0 for every other requester, and for all requesters whenever out_cnt == C_MAX_OUTSTANDING.
- FSM ADDR:
  - m_axi_awvalid=1, with fields held stable until m_axi_awready.
  - On the handshake: next state DATA, out_cnt+1.
  - No W beats are forwarded in ADDR.
- FSM DATA:
  - W path is combinational: m_axi_w* = s_axi_w*[g]; s_axi_wready[g] = m_axi_wready; all other s_axi_wready = 0.
  - A handshake with wlast=1 returns to IDLE.
  - The beat count is not checked against awlen.
- Minimum latency: 1 cycle from s_axi_awvalid to m_axi_awvalid. Back-to-back grants need one IDLE cycle between bursts.
- B routing (combinational):
  - idx = m_axi_bid upper C_IDX_WIDTH bits.
  - If idx < N: s_axi_bvalid[idx] = m_axi_bvalid; s_axi_bid[idx] = low C_ID_WIDTH bits; s_axi_bresp[idx] = m_axi_bresp; m_axi_bready = s_axi_bready[idx].
  - If idx >= N: m_axi_bready=1, nothing is routed, bid_err pulses on the handshake.
- out_cnt (width 8):
  - +1 on m AW handshake; -1 on m B handshake (including dropped B).
  - Both in one cycle: no change. Never underflows; a B handshake at 0 leaves it at 0.
- Fairness: rr_ptr advances only on grant, so any requester holding awvalid is granted within N grants.

Test Plan:
- Single requester 1, awlen=3, 4 W beats, slave always ready -> m_axi_awid={1,id}; AW out 1 cycle after request; 4 W beats forwarded; wlast returns to IDLE; grant_idx=1.
- Requesters 0,1,2 hold awvalid continuously from reset -> grant order 0,1,2,0; each W burst contiguous; no interleaving.
- C_MAX_OUTSTANDING=2, B withheld -> third AW not accepted (s_axi_awready=0); one B handshake -> third grant next IDLE cycle.
- m_axi_bid={2,4'hA}, bresp=2'b10 -> only s_axi_bvalid[2]=1, s_axi_bid[2]=4'hA; m_axi_bready follows s_axi_bready[2].
- N=3, m_axi_bid index 3 -> m_axi_bready=1, bid_err one-cycle pulse, no s_axi_bvalid.
- reset asserted during DATA beat 2 of 4 -> next cycle IDLE, all readys/valids 0, out_cnt=0, rr_ptr=0.
